// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: state encoding, channel field positions and palette defaults for the fade sequencer
package rgb_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FADE_WAIT, UPD_R, UPD_G, UPD_B, HOLD} seq_state_e;
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;
  function automatic logic [2:0] default_mask(input int i);
    return i == 0 ? 3'b100 : i == 1 ? 3'b010 : i == 2 ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/rgb_step_unit.sv
// rgb_step_unit: moves each of three channels one count toward its target and flags when all match
module rgb_step_unit #(
  parameter int W = 9
) (
  input  logic [3*W-1:0] cur,
  input  logic [3*W-1:0] tgt,
  output logic [3*W-1:0] nxt,
  output logic           eq
);
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [W-1:0] a, b;
    assign a = cur[c*W +: W];
    assign b = tgt[c*W +: W];
    assign nxt[c*W +: W] = a < b ? a + 1'b1 : a > b ? a - 1'b1 : a;
  end
  assign eq = cur == tgt;
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: walks a writable palette, fading toward each entry and emitting R/G/B write bursts
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int R          = 8,
  parameter int N_COLORS   = 4,
  parameter int STEP_DIV   = 1000,
  parameter int HOLD_STEPS = 256,
  localparam int IW        = $clog2(N_COLORS),
  localparam int W         = R + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            pal_we_i,
  input  logic [IW-1:0]   pal_addr_i,
  input  logic [3*W-1:0]  pal_data_i,
  output logic [2:0]      change_color_o,
  output logic [W-1:0]    color_intencity_o,
  output logic            busy_o,
  output logic [IW-1:0]   color_idx_o,
  output logic            wrap_o
);
  localparam int CW = $clog2(HOLD_STEPS * STEP_DIV) + 1;
  localparam logic [W-1:0] MAX = W'(2 ** R);
  localparam logic [CW-1:0] DIV_LOAD = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_STEPS * STEP_DIV - 1);
  localparam logic [IW:0] NC = (IW + 1)'(N_COLORS);
  localparam logic [IW-1:0] LAST = IW'(N_COLORS - 1);

  function automatic logic [3*W-1:0] default_entry(input int i);
    logic [2:0] m;
    default_entry = '0;
    m = default_mask(i);
    for (int c = 0; c < 3; c++) default_entry[c*W +: W] = m[c] ? MAX : '0;
  endfunction

  logic [3*W-1:0] pal [N_COLORS];
  logic [3*W-1:0] cur, tgt, nxt;
  logic           eq;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  seq_state_e     state;

  rgb_step_unit #(.W(W)) u_step (.cur(cur), .tgt(tgt), .nxt(nxt), .eq(eq));

  assign busy_o = state != IDLE;
  assign color_idx_o = idx;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)
      for (int i = 0; i < N_COLORS; i++) pal[i] <= default_entry(i);
    else if (pal_we_i && {1'b0, pal_addr_i} < NC)
      pal[pal_addr_i] <= pal_data_i;

  // outputs are registered on the transition into each UPD_* state so strobes line up with the state
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      cur <= '0;
      tgt <= '0;
      cnt <= '0;
      change_color_o <= '0;
      color_intencity_o <= '0;
      wrap_o <= 1'b0;
    end else begin
      change_color_o <= '0;
      wrap_o <= 1'b0;
      case (state)
        IDLE: if (en_i) state <= LOAD;
        LOAD: begin
          tgt <= pal[idx];
          cnt <= DIV_LOAD;
          state <= FADE_WAIT;
        end
        FADE_WAIT:
          if (!en_i) state <= IDLE;
          else if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            cur <= nxt;
            change_color_o <= 3'b001;
            color_intencity_o <= nxt[CH_R*W +: W];
            state <= UPD_R;
          end
        UPD_R: begin
          change_color_o <= 3'b010;
          color_intencity_o <= cur[CH_G*W +: W];
          state <= UPD_G;
        end
        UPD_G: begin
          change_color_o <= 3'b100;
          color_intencity_o <= cur[CH_B*W +: W];
          state <= UPD_B;
        end
        UPD_B: begin
          state <= !en_i ? IDLE : eq ? HOLD : FADE_WAIT;
          cnt <= eq ? HOLD_LOAD : DIV_LOAD;
        end
        HOLD:
          if (!en_i) state <= IDLE;
          else if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            idx <= idx == LAST ? '0 : idx + 1'b1;
            wrap_o <= idx == LAST;
            state <= LOAD;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: random palettes checked against an event-list model of the palette walk
module tb_rgb_fade_sequencer;
  localparam int R = 8, N = 4, SD = 4, HS = 2, W = R + 1, IW = 2, H = HS * SD;

  logic clk = 0, rst = 1, en = 0, pal_we = 0;
  logic [IW-1:0] pal_addr = '0;
  logic [3*W-1:0] pal_data = '0;
  logic [2:0] cc;
  logic [W-1:0] ci;
  logic busy, wrap;
  logic [IW-1:0] cidx;
  int cyc = 0, n_checks = 0, n_errors = 0;
  int m_cur [3];
  int m_pal [N][3];
  int m_idx;
  typedef struct {int cyc; int cc; int val;} ev_t;
  ev_t evq[$], exq[$];
  int wq[$], exw[$];

  rgb_fade_sequencer #(.R(R), .N_COLORS(N), .STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pal_we_i(pal_we), .pal_addr_i(pal_addr),
    .pal_data_i(pal_data), .change_color_o(cc), .color_intencity_o(ci), .busy_o(busy),
    .color_idx_o(cidx), .wrap_o(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cc != 3'b000) evq.push_back('{cyc, int'(cc), int'(ci)});
    if (wrap) wq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_pal(input int a, input int r, input int g, input int b);
    pal_we = 1;
    pal_addr = IW'(a);
    pal_data = {W'(r), W'(g), W'(b)};
    tick();
    pal_we = 0;
    m_pal[a] = '{r, g, b};
  endtask

  task automatic go_idle();
    en = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("idle_busy", busy, 0);
  endtask

  // Build the expected strobe/wrap timeline from palette contents, then drive the DUT and compare.
  task automatic run_walk(input int n_loads, input int race_j, input int rr, input int rg,
                          input int rb, input int drop_b);
    int L, u, nb, race_l, race_a, drop_c, fin;
    int tgt [3];
    int ldq[$], ldi[$];
    bit done, stop;
    L = cyc + 1;
    fin = L;
    nb = 0;
    race_l = -1;
    race_a = 0;
    drop_c = -1;
    stop = 0;
    exq.delete();
    exw.delete();
    for (int j = 0; j < n_loads && !stop; j++) begin
      tgt = m_pal[m_idx];
      ldq.push_back(L);
      ldi.push_back(m_idx);
      if (j == race_j) begin
        race_l = L;
        race_a = m_idx;
        m_pal[m_idx] = '{rr, rg, rb};
      end
      u = L + 1 + SD;
      do begin
        for (int c = 0; c < 3; c++)
          if (m_cur[c] < tgt[c]) m_cur[c]++;
          else if (m_cur[c] > tgt[c]) m_cur[c]--;
        for (int c = 0; c < 3; c++) exq.push_back('{u + c, 1 << c, m_cur[c]});
        nb++;
        done = m_cur[0] == tgt[0] && m_cur[1] == tgt[1] && m_cur[2] == tgt[2];
        if (nb == drop_b) begin
          stop = 1;
          drop_c = u;
          fin = u + 3;
        end else if (!done) u += SD + 3;
      end while (!done && !stop);
      if (!stop) begin
        L = u + 3 + H;
        if (m_idx == N - 1) exw.push_back(L);
        m_idx = (m_idx + 1) % N;
        fin = L;
      end
    end
    if (!stop) begin
      ldq.push_back(fin);
      ldi.push_back(m_idx);
    end
    evq.delete();
    wq.delete();
    en = 1;
    while (cyc < fin) begin
      tick();
      if (cyc == race_l) begin
        pal_we = 1;
        pal_addr = IW'(race_a);
        pal_data = {W'(rr), W'(rg), W'(rb)};
      end else pal_we = 0;
      if (cyc == drop_c) en = 0;
      if (ldq.size() > 0 && cyc == ldq[0]) begin
        check("load_idx", cidx, ldi[0]);
        void'(ldq.pop_front());
        void'(ldi.pop_front());
      end
    end
    if (drop_c >= 0) check("drop_idle", busy, 0);
    tick();
    check("n_events", evq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      check("ev_cycle", evq[i].cyc, exq[i].cyc);
      check("ev_strobe", evq[i].cc, exq[i].cc);
      check("ev_value", evq[i].val, exq[i].val);
    end
    check("n_wraps", wq.size(), exw.size());
    for (int i = 0; i < exw.size() && i < wq.size(); i++) check("wrap_cycle", wq[i], exw[i]);
  endtask

  task automatic rand_pal();
    for (int a = 0; a < N; a++)
      wr_pal(a, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
  endtask

  initial begin
    int strobes;
    bit seen;
    tick();
    check("rst_strobe", cc, 0);
    check("rst_value", ci, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", cidx, 0);
    check("rst_wrap", wrap, 0);
    rst = 0;
    en = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = cc == 3'b010;
    end
    check("reach_upd_g", seen, 1);
    #2 rst = 1;
    en = 0;
    #1;
    check("async_strobe", cc, 0);
    check("async_value", ci, 0);
    check("async_busy", busy, 0);
    check("async_idx", cidx, 0);
    tick();
    rst = 0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cc != 3'b000) strobes++;
    end
    check("idle_strobes", strobes, 0);
    check("idle_busy0", busy, 0);
    m_cur = '{0, 0, 0};
    m_idx = 0;
    for (int a = 0; a < N; a++) m_pal[a] = '{a == 0 ? 256 : 0, a == 1 ? 256 : 0, a == 2 ? 256 : 0};
    wr_pal(0, 3, 0, 0);
    wr_pal(1, 1, 2, 0);
    wr_pal(2, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
    wr_pal(3, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
    run_walk(6, -1, 0, 0, 0, -1);
    go_idle();
    for (int k = 0; k < 2; k++) begin
      tick($urandom_range(1, 5));
      rand_pal();
      run_walk(6, 1, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), -1);
      go_idle();
      tick($urandom_range(1, 5));
      rand_pal();
      run_walk(5, -1, 0, 0, 0, $urandom_range(1, 4));
      tick($urandom_range(1, 6));
      run_walk(5, -1, 0, 0, 0, -1);
      go_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Autonomous colour sequencer that drives the write side of rgb_application (change_color / color_intencity).
- Holds a small writable palette and walks through it in order, wrapping at the end.
- Fades each RGB channel by ±1 per step toward the target colour, then holds the target before advancing.
- Pushes each step as a three-cycle one-hot write burst (R, then G, then B).

Parameters:
- R, 8: PWM resolution; each channel value is R+1 bits, matching the PWM duty width.
- N_COLORS, 4: palette depth; must be ≥2. IW = clog2(N_COLORS).
- STEP_DIV, 1000: clock cycles per fade step; must be ≥1.
- HOLD_STEPS, 256: step periods spent at the target before advancing; must be ≥1.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- en_i  input  1  run enable (level).
- pal_we_i  input  1  palette write strobe.
- pal_addr_i  input  IW  palette write address.
- pal_data_i  input  3*(R+1)  palette entry {r,g,b}, r in MSBs.
- change_color_o  output  3  one-hot channel write strobe to rgb_application.
- color_intencity_o  output  R+1  channel value accompanying the strobe.
- busy_o  output  1  high in any state other than IDLE.
- color_idx_o  output  IW  index of the current target entry.
- wrap_o  output  1  one-cycle pulse when the index wraps from N_COLORS-1 to 0.

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0; state IDLE; index 0.
  - Current colour cur_{r,g,b} = 0; target = 0; divider and hold counters = 0.
  - Palette = package defaults: {max,0,0}, {0,max,0}, {0,0,max}, {0,0,0}, where max = 2^R. Entries beyond 4 reset to 0.
- State machine: IDLE, LOAD, FADE_WAIT, UPD_R, UPD_G, UPD_B, HOLD.
  - IDLE: when en_i=1, go to LOAD.
  - LOAD (1 cycle): target <= palette[index]; go to FADE_WAIT; divider = STEP_DIV-1.
  - FADE_WAIT: divider counts down to 0, then go to UPD_R.
  - UPD_R: update each channel toward target (cur<tgt: +1; cur>tgt: -1; equal: unchanged). Drive change_color_o=001 with the new cur_r.
  - UPD_G: drive change_color_o=010 with cur_g.
  - UPD_B: drive change_color_o=100 with cur_b.
  - After UPD_B:
    - if en_i=0, go to IDLE;
    - else if cur==target, go to HOLD with HOLD_STEPS*STEP_DIV cycles loaded;
    - else go to FADE_WAIT.
  - HOLD: counts down. On expiry, index advances (N_COLORS-1 wraps to 0 with wrap_o=1 for 1 cycle), then go to LOAD. If en_i=0 during HOLD, go to IDLE at once.
- Step period = STEP_DIV+3 cycles. No arithmetic overflow: values move only toward targets within [0, 2^(R+1)-1].
- A change_color_o strobe is never asserted outside UPD_*. change_color_o and color_intencity_o are registered outputs. In all other states change_color_o = 000 and color_intencity_o holds its last value.
- en_i=0 during FADE_WAIT goes to IDLE immediately. en_i=0 during UPD_* completes the burst first, so a burst is never split.
- On re-enable: resumes via LOAD with the same index. cur is retained, so the fade continues from where it stopped.
- Palette write:
  - Takes 1 cycle and is accepted in any state.
  - A write on the same cycle as LOAD to the same address: LOAD uses the pre-write contents.
  - A write to the current target index does not affect the fade in progress.
- The write port must not be driven with more than one strobe bit set.

Decomposition:
- Package rgb_seq_pkg:
  - state enum;
  - palette default constants;
  - channel field offset constants.
- One sub-module: rgb_step_unit, a combinational ±1-toward-target per channel plus an all-equal flag.
- Palette is a register array inside the top module.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_i mid-UPD_G, then release.
  - Required: change_color_o=000, color_intencity_o=0, busy_o=0, color_idx_o=0 immediately. No strobes while en_i=0.
- Ramp up (STEP_DIV=4, HOLD_STEPS=2, palette0={3,0,0}), en_i=1 from reset:
  - First 001/1 strobe in cycle 6 (LOAD + 4 wait cycles).
  - Bursts every 7 cycles: 001/1,010/0,100/0 → 001/2… → 001/3.
  - Then 8 HOLD cycles, then color_idx_o=1.
- Mixed direction:
  - Setup: cur={3,0,0}; entry1 written as {1,2,0}.
  - Required bursts: {2,1,0}, then {1,2,0}, then HOLD.
- Wrap:
  - Stimulus: run through index 3.
  - Required: wrap_o high exactly 1 cycle as color_idx_o goes 3→0; entry0 is reloaded.
- Enable drop:
  - Stimulus: en_i=0 during UPD_R.
  - Required: the 010 and 100 strobes still occur, then IDLE with busy_o=0.
  - Stimulus: re-enable.
  - Required: the fade resumes from the retained cur values.
- Palette write race:
  - Stimulus: pal_we_i to the index being loaded, in the LOAD cycle.
  - Required: the fade targets the old value; the new value is used on the next pass through that index.
